// File: rtl/pc_unit.sv
// Program counter unit: sequential fetch, jump/branch redirect, a one-deep
// pending-redirect register used while stalled, exception entry/return and
// a misaligned-redirect trap.
// Optional build macro PC_DELAY_SLOT_EN: redirects accepted while running
// first step into the delay slot (pc+STEP) and land on the target one
// non-stalled edge later, via the pending register.
module pc_unit #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_ADDR = 32'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_ADDR   = 32'h0000_4180,
    parameter int               STEP       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_en,
    input  logic [WIDTH-1:0] br_target,
    input  logic             j_en,
    input  logic [WIDTH-1:0] j_target,
    input  logic             exc_req,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] epc,
    output logic             addr_err,
    output logic             redirect_pend
);

    logic [WIDTH-1:0] pend_target;
    logic             req_v;
    logic [WIDTH-1:0] req_target;
    logic             app_v;
    logic [WIDTH-1:0] app_target;
    logic             misalign;
    logic [WIDTH-1:0] pc_next_seq;

    // Select the incoming request (jump beats branch) and the target that
    // would land on pc this edge if nothing of higher priority intervenes.
    always_comb begin
        req_v       = j_en | br_en;
        req_target  = j_en ? j_target : br_target;
        pc_next_seq = pc + WIDTH'(STEP);
`ifdef PC_DELAY_SLOT_EN
        // New requests always go through the delay slot first.
        app_v      = redirect_pend;
        app_target = pend_target;
`else
        app_v      = redirect_pend | req_v;
        app_target = redirect_pend ? pend_target : req_target;
`endif
        misalign = app_v && (app_target[1:0] != 2'b00);
    end

    // PC, EPC, pending redirect and error pulse, in priority order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc            <= RESET_ADDR;
            epc           <= '0;
            redirect_pend <= 1'b0;
            pend_target   <= '0;
            addr_err      <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            if (exc_req) begin
                epc           <= pc;
                pc            <= EXC_ADDR;
                redirect_pend <= 1'b0;
            end else if (eret) begin
                pc            <= epc;
                redirect_pend <= 1'b0;
            end else if (!stall && misalign) begin
                // Trap instead of fetching from a misaligned address.
                pc            <= EXC_ADDR;
                epc           <= app_target;
                addr_err      <= 1'b1;
                redirect_pend <= 1'b0;
            end else if (stall) begin
                // Hold pc; first request seen while held is remembered.
                if (!redirect_pend && req_v) begin
                    redirect_pend <= 1'b1;
                    pend_target   <= req_target;
                end
            end else if (redirect_pend) begin
                pc            <= pend_target;
                redirect_pend <= 1'b0;
            end else if (req_v) begin
`ifdef PC_DELAY_SLOT_EN
                pc            <= pc_next_seq;
                redirect_pend <= 1'b1;
                pend_target   <= req_target;
`else
                pc            <= req_target;
`endif
            end else begin
                pc <= pc_next_seq;
            end
        end
    end

endmodule
